// File: rtl/id_stage_pipe_if.sv
// Decode-side and ID/EX-side handshake bundle for the MIPS ID stage.
// master drives the instruction and consumes the latch; slave is the stage.
interface id_stage_pipe_if #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
);
    // upstream (IF/CU) side
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       ir;
    logic              syscall;
    logic              unsigned_ext;
    logic              reg_dst;
    logic              jr;
    logic              jal;
    logic              flush;

    // downstream (EX) side
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_rd1;
    logic [DATA_W-1:0] out_rd2;
    logic [RA_W-1:0]   out_wb_num;
    logic [DATA_W-1:0] out_imm;
    logic [4:0]        out_shamt;
    logic [DATA_W-1:0] out_jaddr;

    modport master (
        output in_valid, ir, syscall, unsigned_ext,
        output reg_dst, jr, jal, flush, out_ready,
        input  in_ready, out_valid, out_rd1, out_rd2,
        input  out_wb_num, out_imm, out_shamt, out_jaddr
    );

    modport slave (
        input  in_valid, ir, syscall, unsigned_ext,
        input  reg_dst, jr, jal, flush, out_ready,
        output in_ready, out_valid, out_rd1, out_rd2,
        output out_wb_num, out_imm, out_shamt, out_jaddr
    );
endinterface

// File: rtl/id_stage_pipe.sv
// MIPS instruction-decode stage: register file, HI/LO, field decode
// and a valid/ready ID/EX output latch with stall and flush.
module id_stage_pipe #(
    parameter int DATA_W   = 32,
    parameter int NREG     = 32,
    parameter int SYS_R1   = 4,
    parameter int SYS_R2   = 2,
    parameter int LINK_REG = 31
) (
    input  logic                      clk,
    input  logic                      rst_n,
    id_stage_pipe_if.slave            bus,
    input  logic                      wb_en_i,
    input  logic [$clog2(NREG)-1:0]   wb_num_i,
    input  logic [DATA_W-1:0]         wb_data_i,
    input  logic                      hi_write_i,
    input  logic                      lo_write_i,
    input  logic [DATA_W-1:0]         hi_in_i,
    output logic [DATA_W-1:0]         hi_o,
    output logic [DATA_W-1:0]         lo_o
);
    localparam int RA_W = $clog2(NREG);

    typedef logic [RA_W-1:0]   ra_t;
    typedef logic [DATA_W-1:0] dw_t;

    // architectural state
    dw_t regs_q [NREG];
    dw_t hi_q, hi_d;
    dw_t lo_q, lo_d;

    // ID/EX latch
    logic   out_valid_q, out_valid_d;
    dw_t    rd1_q, rd1_d;
    dw_t    rd2_q, rd2_d;
    ra_t    wbn_q, wbn_d;
    dw_t    imm_q, imm_d;
    logic [4:0] shamt_q, shamt_d;
    dw_t    jaddr_q, jaddr_d;

    // decode results
    ra_t  r1, r2, dest;
    dw_t  rd1, rd2, imm, jaddr;
    logic in_ready;
    logic accept;

    // register numbers; syscall redirects to the ABI argument registers
    always_comb begin
        r1 = ra_t'(bus.ir[25:21]);
        r2 = ra_t'(bus.ir[20:16]);
        if (bus.syscall) begin
            r1 = ra_t'(SYS_R1);
            r2 = ra_t'(SYS_R2);
        end
    end

    // read port 1 with r0 forced to zero and write-through bypass
    always_comb begin
        rd1 = '0;
        if (r1 != '0) begin
            if (wb_en_i && (wb_num_i == r1)) rd1 = wb_data_i;
            else                             rd1 = regs_q[r1];
        end
    end

    // read port 2, same rules as port 1
    always_comb begin
        rd2 = '0;
        if (r2 != '0) begin
            if (wb_en_i && (wb_num_i == r2)) rd2 = wb_data_i;
            else                             rd2 = regs_q[r2];
        end
    end

    // destination select: jal overrides reg_dst
    always_comb begin
        dest = ra_t'(bus.ir[20:16]);
        unique case ({bus.jal, bus.reg_dst})
            2'b10, 2'b11: dest = ra_t'(LINK_REG);
            2'b01:        dest = ra_t'(bus.ir[15:11]);
            default:      dest = ra_t'(bus.ir[20:16]);
        endcase
    end

    // immediate extension and jump target
    always_comb begin
        if (bus.unsigned_ext) imm = {{(DATA_W-16){1'b0}}, bus.ir[15:0]};
        else                  imm = {{(DATA_W-16){bus.ir[15]}}, bus.ir[15:0]};
        if (bus.jr) jaddr = rd1;
        else        jaddr = {{(DATA_W-26){1'b0}}, bus.ir[25:0]};
    end

    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    // latch next state: load on accept, drop on drain, flush kills valid
    always_comb begin
        out_valid_d = out_valid_q;
        rd1_d       = rd1_q;
        rd2_d       = rd2_q;
        wbn_d       = wbn_q;
        imm_d       = imm_q;
        shamt_d     = shamt_q;
        jaddr_d     = jaddr_q;
        if (accept) begin
            out_valid_d = 1'b1;
            rd1_d       = rd1;
            rd2_d       = rd2;
            wbn_d       = dest;
            imm_d       = imm;
            shamt_d     = bus.ir[10:6];
            jaddr_d     = jaddr;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (bus.flush) out_valid_d = 1'b0;
    end

    // HI/LO next state, independent of the handshake
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (hi_write_i) hi_d = hi_in_i;
        if (lo_write_i) lo_d = wb_data_i;
    end

    // register file write port; r0 is never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (wb_en_i && (wb_num_i != '0)) begin
            regs_q[wb_num_i] <= wb_data_i;
        end
    end

    // HI/LO registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // ID/EX latch registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            wbn_q       <= '0;
            imm_q       <= '0;
            shamt_q     <= '0;
            jaddr_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
            wbn_q       <= wbn_d;
            imm_q       <= imm_d;
            shamt_q     <= shamt_d;
            jaddr_q     <= jaddr_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_rd1    = rd1_q;
    assign bus.out_rd2    = rd2_q;
    assign bus.out_wb_num = wbn_q;
    assign bus.out_imm    = imm_q;
    assign bus.out_shamt  = shamt_q;
    assign bus.out_jaddr  = jaddr_q;
    assign hi_o           = hi_q;
    assign lo_o           = lo_q;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed spec scenarios
// plus randomized traffic against a transaction-level reference model.
module tb_id_stage_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_en;
    logic [4:0]  wb_num;
    logic [31:0] wb_data;
    logic        hi_write;
    logic        lo_write;
    logic [31:0] hi_in;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    id_stage_pipe_if #(.DATA_W(32), .RA_W(5)) bus ();

    id_stage_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .wb_en_i    (wb_en),
        .wb_num_i   (wb_num),
        .wb_data_i  (wb_data),
        .hi_write_i (hi_write),
        .lo_write_i (lo_write),
        .hi_in_i    (hi_in),
        .hi_o       (hi),
        .lo_o       (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [4:0]  wbn;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [31:0] jaddr;
    } dec_t;

    // reference model state
    logic [31:0] m_rf [32];
    logic [31:0] m_hi, m_lo;
    logic        m_valid;
    dec_t        m_out;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_hi    = '0;
        m_lo    = '0;
        m_valid = 1'b0;
        m_out   = '{default: '0};
    endtask

    // architectural read as seen this cycle (write-through visible)
    function automatic logic [31:0] mread(input logic [4:0] n);
        if (n == 0) return 32'h0;
        if (wb_en && wb_num == n) return wb_data;
        return m_rf[n];
    endfunction

    function automatic dec_t decode();
        dec_t d;
        logic [4:0] a, b;
        a = bus.syscall ? 5'd4 : bus.ir[25:21];
        b = bus.syscall ? 5'd2 : bus.ir[20:16];
        d.rd1 = mread(a);
        d.rd2 = mread(b);
        if (bus.jal)          d.wbn = 5'd31;
        else if (bus.reg_dst) d.wbn = bus.ir[15:11];
        else                  d.wbn = bus.ir[20:16];
        d.imm = bus.ir & 32'h0000_FFFF;
        if (!bus.unsigned_ext && bus.ir[15]) d.imm = d.imm | 32'hFFFF_0000;
        d.jaddr = bus.jr ? d.rd1 : (bus.ir & 32'h03FF_FFFF);
        d.shamt = bus.ir[10:6];
        return d;
    endfunction

    // one clock: called at negedge with inputs set, returns at next negedge
    task automatic cycle();
        dec_t d;
        logic take, keep;
        #1;
        chk("in_ready", bus.in_ready, !m_valid || bus.out_ready);
        d    = decode();
        take = bus.in_valid && (!m_valid || bus.out_ready);
        keep = m_valid && !bus.out_ready;
        @(posedge clk);
        if (wb_en && wb_num != 0) m_rf[wb_num] = wb_data;
        if (hi_write) m_hi = hi_in;
        if (lo_write) m_lo = wb_data;
        if (take) m_out = d;
        m_valid = (take || keep) && !bus.flush;
        #1;
        chk("out_valid", bus.out_valid, m_valid);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        if (m_valid) begin
            chk("out_rd1", bus.out_rd1, m_out.rd1);
            chk("out_rd2", bus.out_rd2, m_out.rd2);
            chk("out_wb_num", bus.out_wb_num, m_out.wbn);
            chk("out_imm", bus.out_imm, m_out.imm);
            chk("out_shamt", bus.out_shamt, m_out.shamt);
            chk("out_jaddr", bus.out_jaddr, m_out.jaddr);
        end
        @(negedge clk);
    endtask

    task automatic set_idle();
        bus.in_valid     = 1'b0;
        bus.ir           = '0;
        bus.syscall      = 1'b0;
        bus.unsigned_ext = 1'b0;
        bus.reg_dst      = 1'b0;
        bus.jr           = 1'b0;
        bus.jal          = 1'b0;
        bus.flush        = 1'b0;
        bus.out_ready    = 1'b1;
        wb_en            = 1'b0;
        wb_num           = '0;
        wb_data          = '0;
        hi_write         = 1'b0;
        lo_write         = 1'b0;
        hi_in            = '0;
    endtask

    task automatic wr(input logic [4:0] n, input logic [31:0] v);
        set_idle();
        wb_en   = 1'b1;
        wb_num  = n;
        wb_data = v;
        cycle();
    endtask

    initial begin
        set_idle();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_rd1", bus.out_rd1, 32'h0);
        rst_n = 1'b1;

        // bypass on rs=8, then r0 ignores writes
        set_idle();
        bus.in_valid = 1'b1;
        bus.ir       = {6'h0, 5'd8, 21'h0};
        wb_en = 1'b1; wb_num = 5'd8; wb_data = 32'hDEAD_BEEF;
        cycle();
        chk("bypass_rd1", bus.out_rd1, 32'hDEAD_BEEF);
        bus.ir = 32'h0;
        wb_num = 5'd0; wb_data = 32'h7;
        cycle();
        chk("r0_zero", bus.out_rd1, 32'h0);

        // immediate extension, jal link, jr target
        set_idle();
        bus.in_valid = 1'b1;
        bus.ir       = 32'h2000_8001;
        cycle();
        chk("imm_sext", bus.out_imm, 32'hFFFF_8001);
        bus.unsigned_ext = 1'b1;
        cycle();
        chk("imm_zext", bus.out_imm, 32'h0000_8001);
        bus.unsigned_ext = 1'b0;
        bus.jal = 1'b1; bus.reg_dst = 1'b1;
        cycle();
        chk("jal_dest", bus.out_wb_num, 32'd31);
        wr(5'd9, 32'h400);
        bus.in_valid = 1'b1;
        bus.ir = {6'h0, 5'd9, 21'h0};
        bus.jr = 1'b1;
        cycle();
        chk("jr_target", bus.out_jaddr, 32'h400);

        // HI/LO together, then syscall operand redirect
        set_idle();
        hi_write = 1'b1; hi_in = 32'h12;
        lo_write = 1'b1; wb_data = 32'h34;
        cycle();
        chk("hi_val", hi, 32'h12);
        chk("lo_val", lo, 32'h34);
        wr(5'd4, 32'h44);
        wr(5'd2, 32'h22);
        bus.in_valid = 1'b1;
        bus.ir       = 32'hFFFF_FFFF;
        bus.syscall  = 1'b1;
        cycle();
        chk("sys_rd1", bus.out_rd1, 32'h44);
        chk("sys_rd2", bus.out_rd2, 32'h22);

        // stall for 3 cycles, then the waiting instruction loads once
        set_idle();
        bus.in_valid = 1'b1;
        bus.ir       = 32'h0000_1111;
        cycle();
        bus.ir        = 32'h0000_2222;
        bus.out_ready = 1'b0;
        repeat (3) begin
            cycle();
            chk("stall_in_ready", bus.in_ready, 1'b0);
            chk("stall_hold", bus.out_imm, 32'h1111);
        end
        bus.out_ready = 1'b1;
        cycle();
        chk("stall_next", bus.out_imm, 32'h2222);
        bus.in_valid = 1'b0;
        cycle();
        chk("drain", bus.out_valid, 1'b0);

        // flush with accept, then flush during stall
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        cycle();
        chk("flush_acc", bus.out_valid, 1'b0);
        bus.flush = 1'b0;
        cycle();
        bus.out_ready = 1'b0;
        bus.flush     = 1'b1;
        cycle();
        chk("flush_stall", bus.out_valid, 1'b0);
        bus.flush = 1'b0;
        #1;
        chk("flush_ready", bus.in_ready, 1'b1);
        cycle();

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            bus.in_valid     = ($urandom_range(0, 3) != 0);
            bus.out_ready    = ($urandom_range(0, 2) != 0);
            bus.flush        = ($urandom_range(0, 15) == 0);
            bus.ir           = $urandom;
            bus.syscall      = ($urandom_range(0, 7) == 0);
            bus.unsigned_ext = 1'($urandom);
            bus.reg_dst      = 1'($urandom);
            bus.jr           = ($urandom_range(0, 3) == 0);
            bus.jal          = ($urandom_range(0, 3) == 0);
            wb_en            = 1'($urandom);
            wb_num           = 5'($urandom);
            wb_data          = $urandom;
            hi_write         = ($urandom_range(0, 3) == 0);
            lo_write         = ($urandom_range(0, 3) == 0);
            hi_in            = $urandom;
            cycle();
        end

        // reset asserted mid-stall
        set_idle();
        bus.in_valid = 1'b1;
        bus.ir       = 32'h00A5_0000;
        hi_write = 1'b1; hi_in = 32'h99;
        cycle();
        bus.out_ready = 1'b0;
        hi_write      = 1'b0;
        cycle();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", bus.out_valid, 1'b0);
        chk("rst_mid_hi", hi, 32'h0);
        chk("rst_mid_lo", lo, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        bus.ir = {6'h0, 5'd5, 21'h0};
        cycle();
        chk("rst_r5", bus.out_rd1, 32'h0);
        chk("rst_valid_after", bus.out_valid, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
